// File: rtl/dvp_frame_gen.sv
// rtl/dvp_frame_gen.sv - DVP (OV5640-style) RGB565 test-pattern video source
// Outputs are registered from the next-cycle position, so they line up with the state registers.
module dvp_frame_gen #(
    parameter int H_PIXEL   = 480,
    parameter int V_PIXEL   = 272,
    parameter int H_BLANK   = 64,
    parameter int VS_LINES  = 2,
    parameter int VBP_LINES = 4,
    parameter int VFP_LINES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int          LINE_CLKS = 2 * H_PIXEL + H_BLANK;
    localparam logic [15:0] LC_LAST   = 16'(LINE_CLKS - 1);
    localparam logic [15:0] ACT_BYTES = 16'(2 * H_PIXEL);
    localparam logic [15:0] BAR_LAST  = 16'(H_PIXEL / 8 - 1);
    localparam logic [15:0] VFP_LAST  = 16'(VFP_LINES - 1);

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t      state, state_n;
    logic [15:0] h_cnt, h_n, v_cnt, v_n, v_last;
    logic [15:0] bar_rem, bar_rem_n;
    logic [2:0]  bar_idx, bar_idx_n;
    logic [1:0]  pat;
    logic [15:0] solid;
    logic [15:0] pixel;
    logic        href_n, done_n;

    always_comb begin
        case (state)
            VSYNC:   v_last = 16'(VS_LINES - 1);
            VBP:     v_last = 16'(VBP_LINES - 1);
            ACTIVE:  v_last = 16'(V_PIXEL - 1);
            VFP:     v_last = VFP_LAST;
            default: v_last = 16'd0;
        endcase
    end

    always_comb begin
        state_n = state;
        h_n     = h_cnt + 16'd1;
        v_n     = v_cnt;
        if (state == IDLE) begin
            h_n = 16'd0;
            v_n = 16'd0;
            if (en) state_n = VSYNC;
        end else if (h_cnt == LC_LAST) begin
            h_n = 16'd0;
            if (v_cnt == v_last) begin
                v_n = 16'd0;
                case (state)
                    VSYNC:   state_n = VBP;
                    VBP:     state_n = ACTIVE;
                    ACTIVE:  state_n = VFP;
                    default: state_n = en ? VSYNC : IDLE;
                endcase
            end else begin
                v_n = v_cnt + 16'd1;
            end
        end
    end

    // Bar position tracked by a per-pixel down-counter instead of dividing x.
    always_comb begin
        bar_idx_n = bar_idx;
        bar_rem_n = bar_rem;
        if (h_n == 16'd0) begin
            bar_idx_n = 3'd0;
            bar_rem_n = BAR_LAST;
        end else if (!h_n[0]) begin
            if (bar_rem == 16'd0) begin
                bar_idx_n = bar_idx + 3'd1;
                bar_rem_n = BAR_LAST;
            end else begin
                bar_rem_n = bar_rem - 16'd1;
            end
        end
    end

    always_comb begin
        pixel = 16'h0000;
        case (pat)
            2'd0: begin
                case (bar_idx_n)
                    3'd0:    pixel = 16'hFFFF;
                    3'd1:    pixel = 16'hFFE0;
                    3'd2:    pixel = 16'h07FF;
                    3'd3:    pixel = 16'h07E0;
                    3'd4:    pixel = 16'hF81F;
                    3'd5:    pixel = 16'hF800;
                    3'd6:    pixel = 16'h001F;
                    default: pixel = 16'h0000;
                endcase
            end
            2'd1:    pixel = solid;
            2'd2:    pixel = {h_n[5:1], h_n[6:1], h_n[5:1]};
            default: pixel = (h_n[5] ^ v_n[4]) ? 16'hFFFF : 16'h0000;
        endcase
        href_n = (state_n == ACTIVE) && (h_n < ACT_BYTES);
        done_n = (state_n == VFP) && (h_n == LC_LAST) && (v_n == VFP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            h_cnt      <= 16'd0;
            v_cnt      <= 16'd0;
            bar_idx    <= 3'd0;
            bar_rem    <= 16'd0;
            pat        <= 2'd0;
            solid      <= 16'd0;
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= 8'h00;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            state      <= state_n;
            h_cnt      <= h_n;
            v_cnt      <= v_n;
            bar_idx    <= bar_idx_n;
            bar_rem    <= bar_rem_n;
            if (state_n == VSYNC && state != VSYNC) begin
                pat   <= pattern_sel;
                solid <= solid_rgb;
            end
            dvp_vsync  <= (state_n == VSYNC);
            dvp_href   <= href_n;
            dvp_data   <= href_n ? (h_n[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
            busy       <= (state_n != IDLE);
            frame_done <= done_n;
            if (done_n) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_dvp_frame_gen.sv
// tb/tb_dvp_frame_gen.sv - directed self-checking bench for dvp_frame_gen
module tb_dvp_frame_gen;
    logic        clk = 1'b0;
    logic        rst, en, en2;
    logic [1:0]  psel, psel2;
    logic [15:0] solid, solid2;
    logic        vs, hr, bsy, fd, vs2, hr2, bsy2, fd2;
    logic [7:0]  dat, dat2;
    logic [15:0] fcnt, fcnt2;

    int passed = 0;
    int total  = 0;

    logic       v_a  [0:419];
    logic       h_a  [0:419];
    logic       b_a  [0:419];
    logic       fd_a [0:419];
    logic [7:0] d_a  [0:419];

    logic [7:0] bars_exp [0:15] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    always #5 clk = ~clk;

    dvp_frame_gen #(.H_PIXEL(8), .V_PIXEL(4), .H_BLANK(4),
                    .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(psel), .solid_rgb(solid),
        .dvp_vsync(vs), .dvp_href(hr), .dvp_data(dat), .busy(bsy),
        .frame_done(fd), .frame_cnt(fcnt)
    );

    dvp_frame_gen #(.H_PIXEL(32), .V_PIXEL(32), .H_BLANK(4),
                    .VS_LINES(1), .VBP_LINES(1), .VFP_LINES(1)) u2 (
        .clk(clk), .rst(rst), .en(en2), .pattern_sel(psel2), .solid_rgb(solid2),
        .dvp_vsync(vs2), .dvp_href(hr2), .dvp_data(dat2), .busy(bsy2),
        .frame_done(fd2), .frame_cnt(fcnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic sample(input int c);
        v_a[c]  = vs;
        h_a[c]  = hr;
        b_a[c]  = bsy;
        fd_a[c] = fd;
        d_a[c]  = dat;
    endtask

    initial begin
        int n, m;
        rst = 1'b1; en = 1'b0; en2 = 1'b0;
        psel = 2'd0; psel2 = 2'd0; solid = 16'h0000; solid2 = 16'h0000;
        tick(); tick();
        chk("rst_vsync", vs, 0);
        chk("rst_href", hr, 0);
        chk("rst_data", dat, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_fcnt", fcnt, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", bsy, 0);

        // colour bars, three back-to-back frames
        en = 1'b1;
        for (int c = 0; c < 420; c++) begin
            tick();
            sample(c);
        end
        chk("vs_first", v_a[0], 1);
        chk("vs_last_high", v_a[19], 1);
        chk("vs_fall", v_a[20], 0);
        n = 0;
        for (int c = 0; c < 140; c++) if (v_a[c]) n++;
        chk("vs_width", n, 20);
        for (int k = 0; k < 16; k++) chk($sformatf("bar_byte%0d", k), d_a[40+k], bars_exp[k]);
        n = 0;
        for (int c = 56; c < 60; c++) if (h_a[c] !== 1'b0 || d_a[c] !== 8'h00) n++;
        chk("hblank_quiet", n, 0);
        n = 0; m = 0;
        for (int c = 1; c < 140; c++) begin
            if (h_a[c]) m++;
            if (h_a[c] && !h_a[c-1]) n++;
        end
        chk("href_pulses", n, 4);
        chk("href_bytes", m, 64);
        n = 0;
        for (int c = 0; c < 420; c++) if (fd_a[c]) n++;
        chk("fd_count", n, 3);
        chk("fd_f1", fd_a[139], 1);
        chk("fd_f2", fd_a[279], 1);
        chk("fd_f3", fd_a[419], 1);
        chk("vs_rise_140", {v_a[139], v_a[140]}, 2'b01);
        chk("vs_rise_280", {v_a[279], v_a[280]}, 2'b01);
        chk("fcnt_3", fcnt, 3);
        // en drops on the last VFP clock: that sample decides IDLE
        en = 1'b0;
        tick();
        chk("lastvfp_busy", bsy, 0);
        chk("lastvfp_vsync", vs, 0);

        // solid colour, mid-frame solid change, en dropped during frame 2 ACTIVE
        psel = 2'd1; solid = 16'hA5C3; en = 1'b1;
        for (int c = 0; c < 300; c++) begin
            tick();
            sample(c);
            if (c == 60) solid = 16'h1234;
            if (c == 200) en = 1'b0;
        end
        n = 0;
        for (int l = 0; l < 4; l++)
            for (int h = 0; h < 16; h++)
                if (d_a[40 + 20*l + h] !== ((h % 2) ? 8'hC3 : 8'hA5)) n++;
        chk("solid_f1_bytes", n, 0);
        chk("solid_f2_hi", d_a[180], 8'h12);
        chk("solid_f2_lo", d_a[181], 8'h34);
        chk("drop_fd", fd_a[279], 1);
        chk("drop_busy_at_fd", b_a[279], 1);
        chk("drop_busy_after", b_a[280], 0);
        n = 0;
        for (int c = 280; c < 300; c++) if (v_a[c] || h_a[c] || b_a[c] || fd_a[c] || d_a[c] != 8'h00) n++;
        chk("drop_idle_quiet", n, 0);
        chk("fcnt_5", fcnt, 5);

        // reset in the middle of an active line
        psel = 2'd0; en = 1'b1;
        for (int c = 0; c < 46; c++) tick();
        chk("pre_rst_href", hr, 1);
        chk("pre_rst_data", dat, 8'hFF);
        rst = 1'b1;
        tick();
        chk("midrst_href", hr, 0);
        chk("midrst_vsync", vs, 0);
        chk("midrst_data", dat, 0);
        chk("midrst_busy", bsy, 0);
        chk("midrst_fcnt", fcnt, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_vsync", vs, 1);
        en = 1'b0;

        // checkerboard then ramp on the 32x32 instance
        psel2 = 2'd3; en2 = 1'b1;
        for (int c = 0; c < 2530; c++) begin
            tick();
            if (c == 100) psel2 = 2'd2;
            if (c == 136)  chk("chk_0_0_hi", dat2, 8'h00);
            if (c == 137)  chk("chk_0_0_lo", dat2, 8'h00);
            if (c == 168)  chk("chk_16_0_hi", dat2, 8'hFF);
            if (c == 169)  chk("chk_16_0_lo", dat2, 8'hFF);
            if (c == 1224) chk("chk_0_16", dat2, 8'hFF);
            if (c == 1256) chk("chk_16_16", dat2, 8'h00);
            if (c == 2526) chk("ramp_x5_hi", dat2, 8'h28);
            if (c == 2527) chk("ramp_x5_lo", dat2, 8'hA5);
        end
        chk("u2_fcnt", fcnt2, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
